// File: rtl/kyber_pkg.sv
// Shared Baby-Kyber constants, coefficient types and scalar helpers.
package kyber_pkg;

   localparam int Q     = 17;
   localparam int N     = 4;
   localparam int K     = 2;
   localparam int W     = 32;
   localparam int QW    = $clog2(Q);
   localparam int NW    = (N > 1) ? $clog2(N) : 1;
   localparam int KW    = (K > 1) ? $clog2(K) : 1;
   localparam int ACC_W = 2 * QW + $clog2(K * N) + 2;

   typedef logic signed [W-1:0]     coeff_t;
   typedef coeff_t [N-1:0]          poly_t;
   typedef poly_t [K-1:0]           polyvec_t;
   typedef logic [QW-1:0]           resid_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FINAL} state_t;

   // Reduce any signed coefficient to its canonical residue in [0,Q-1].
   function automatic resid_t mod_q(input coeff_t x);
      coeff_t r;
      r = x % coeff_t'(Q);
      if (r < 0) r = r + coeff_t'(Q);
      return resid_t'(r);
   endfunction

   // A residue decodes to 1 when it is closer to Q/2 than to 0 (mod Q).
   function automatic logic decode_bit(input resid_t r);
      int t;
      t = 4 * int'(r);
      return (t > Q) && (t < 3 * Q);
   endfunction

endpackage

// File: rtl/kyber_mac_unit.sv
// Accumulator bank for the negacyclic product: one a*b term per enabled edge,
// added at index i+j or subtracted at i+j-N when the x^N = -1 wrap applies.
module kyber_mac_unit
   import kyber_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   input  logic [NW-1:0] i,
   input  logic [NW-1:0] j,
   input  resid_t        a,
   input  resid_t        b,
   output acc_t          acc [N]
);

   logic [2*QW-1:0] prod;
   logic [NW:0]     sum;
   logic            wrap;
   logic [NW-1:0]   tgt;
   acc_t            term;

   // Product and negacyclic target selection for the current (i,j) pair.
   always_comb begin
      prod = a * b;
      term = acc_t'(prod);
      sum  = {1'b0, i} + {1'b0, j};
      wrap = (sum >= (NW+1)'(N));
      tgt  = wrap ? NW'(sum - (NW+1)'(N)) : NW'(sum);
   end

   // Accumulator bank: cleared at operation start, updated once per MAC edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < N; n++) acc[n] <= '0;
      end else if (clear) begin
         for (int n = 0; n < N; n++) acc[n] <= '0;
      end else if (en) begin
         acc[tgt] <= wrap ? (acc[tgt] - term) : (acc[tgt] + term);
      end
   end

endmodule

// File: rtl/kyber_decrypt.sv
// Baby-Kyber decryption: w = v - s^T.u over Z_Q[x]/(x^N+1), one product per
// edge, then each coefficient of w is decoded to one message bit.
module kyber_decrypt
   import kyber_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  polyvec_t      secretkey,
   input  polyvec_t      u,
   input  poly_t         v,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  msg,
   output poly_t         noisy
);

   state_t        state, state_next;
   logic          clear, en, last, accept;
   resid_t        sr [K][N];
   resid_t        ur [K][N];
   resid_t        vr [N];
   resid_t        w_res [N];
   logic [KW-1:0] k_cnt;
   logic [NW-1:0] i_cnt, j_cnt;
   acc_t          acc [N];

   assign accept = (state == ST_IDLE) && start;
   assign last   = (k_cnt == KW'(K-1)) && (i_cnt == NW'(N-1)) && (j_cnt == NW'(N-1));
   assign busy   = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_next = state;
      clear      = 1'b0;
      en         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               clear      = 1'b1;
               state_next = ST_MAC;
            end
         end
         ST_MAC: begin
            en = 1'b1;
            if (last) state_next = ST_FINAL;
         end
         ST_FINAL: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Latch reduced operands on the accepted start edge; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < K; k++) begin
            for (int n = 0; n < N; n++) begin
               sr[k][n] <= mod_q(secretkey[k][n]);
               ur[k][n] <= mod_q(u[k][n]);
            end
         end
         for (int n = 0; n < N; n++) vr[n] <= mod_q(v[n]);
      end
   end

   // Term counter: j innermost, then i, then k.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         k_cnt <= '0;
         i_cnt <= '0;
         j_cnt <= '0;
      end else if (en) begin
         if (j_cnt == NW'(N-1)) begin
            j_cnt <= '0;
            if (i_cnt == NW'(N-1)) begin
               i_cnt <= '0;
               k_cnt <= k_cnt + 1'b1;
            end else begin
               i_cnt <= i_cnt + 1'b1;
            end
         end else begin
            j_cnt <= j_cnt + 1'b1;
         end
      end
   end

   kyber_mac_unit u_mac (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .en    (en),
      .i     (i_cnt),
      .j     (j_cnt),
      .a     (sr[k_cnt][i_cnt]),
      .b     (ur[k_cnt][j_cnt]),
      .acc   (acc)
   );

   // Final residues w[i] = (v[i] - acc[i]) mod Q.
   always_comb begin
      for (int n = 0; n < N; n++) begin
         w_res[n] = mod_q(coeff_t'(signed'({1'b0, vr[n]})) - coeff_t'(acc[n]));
      end
   end

   // Result registers and the one-cycle done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done  <= 1'b0;
         msg   <= '0;
         noisy <= '0;
      end else begin
         done <= (state == ST_FINAL);
         if (state == ST_FINAL) begin
            for (int n = 0; n < N; n++) begin
               noisy[n] <= coeff_t'(w_res[n]);
               msg[n]   <= decode_bit(w_res[n]);
            end
         end
      end
   end

endmodule

// File: tb/tb_kyber_decrypt.sv
// Scoreboard bench for kyber_decrypt: a stimulus process queues expected
// results from a polynomial-arithmetic model; a monitor checks every done.
module tb_kyber_decrypt;
   import kyber_pkg::*;

   localparam int LAT = K * N * N + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   polyvec_t     secretkey;
   polyvec_t     u;
   poly_t        v;
   logic         busy;
   logic         done;
   logic [N-1:0] msg;
   poly_t        noisy;

   typedef struct {
      poly_t        noisy;
      logic [N-1:0] msg;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   kyber_decrypt dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .secretkey (secretkey),
      .u         (u),
      .v         (v),
      .busy      (busy),
      .done      (done),
      .msg       (msg),
      .noisy     (noisy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endfunction

   function automatic int red(input int x);
      int r;
      r = x % Q;
      if (r < 0) r += Q;
      return r;
   endfunction

   // Reference: full product of each s_k*u_k, folded with x^N = -1.
   function automatic exp_t model(input polyvec_t s, input polyvec_t uu, input poly_t vv);
      exp_t e;
      int   prod [2*N];
      int   w;
      e.noisy = '0;
      e.msg   = '0;
      e.cyc   = 0;
      for (int d = 0; d < 2 * N; d++) prod[d] = 0;
      for (int k = 0; k < K; k++)
         for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
               prod[a+b] += red(int'(s[k][a])) * red(int'(uu[k][b]));
      for (int n = 0; n < N; n++) begin
         w = red(red(int'(vv[n])) - prod[n] + prod[n+N]);
         e.noisy[n] = coeff_t'(w);
         e.msg[n]   = (4 * w > Q) && (4 * w < 3 * Q);
      end
      return e;
   endfunction

   function automatic coeff_t rnd_coeff();
      if ($urandom_range(0, 7) == 0) return coeff_t'($urandom);
      return coeff_t'(int'($urandom_range(0, 64)) - 32);
   endfunction

   function automatic polyvec_t mk_vec(input int a [K][N]);
      polyvec_t r;
      for (int k = 0; k < K; k++)
         for (int n = 0; n < N; n++) r[k][n] = coeff_t'(a[k][n]);
      return r;
   endfunction

   function automatic poly_t mk_poly(input int a [N]);
      poly_t r;
      for (int n = 0; n < N; n++) r[n] = coeff_t'(a[n]);
      return r;
   endfunction

   task automatic scramble();
      for (int k = 0; k < K; k++)
         for (int n = 0; n < N; n++) begin
            secretkey[k][n] = rnd_coeff();
            u[k][n]         = rnd_coeff();
         end
      for (int n = 0; n < N; n++) v[n] = rnd_coeff();
   endtask

   // One operation; optionally pulse start or assert rst at a given edge count.
   task automatic run_op(input polyvec_t s_in, input polyvec_t u_in, input poly_t v_in,
                         input int pulse_at, input int abort_at);
      exp_t e;
      @(negedge clk);
      secretkey = s_in;
      u         = u_in;
      v         = v_in;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e     = model(s_in, u_in, v_in);
      e.cyc = cyc;
      sb.push_back(e);
      for (int ed = 1; ed <= LAT + 20 && sb.size() > 0; ed++) begin
         @(negedge clk);
         start = (ed == pulse_at);
         scramble();
         if (ed == 5) chk("busy_mid_op", busy, 1);
         if (ed == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_msg", msg, 0);
            chk("abort_noisy", noisy, 0);
            sb.delete();
            @(negedge clk);
            rst = 1'b0;
            repeat (LAT + 3) @(negedge clk);
            return;
         end
      end
      start = 1'b0;
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done, expected done after %0d edges", LAT);
         sb.delete();
      end
   endtask

   // Monitor: every done must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            for (int n = 0; n < N; n++) chk($sformatf("noisy[%0d]", n), noisy[n], e.noisy[n]);
            chk("msg", msg, e.msg);
            chk("latency", cyc - e.cyc, LAT);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   initial begin
      int s1 [K][N] = '{'{0, 1, -1, -1}, '{0, -1, 0, -1}};
      int z2 [K][N] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
      int sw [K][N] = '{'{0, 1, 0, 0}, '{0, 0, 0, 0}};
      int uw [K][N] = '{'{0, 0, 0, 1}, '{0, 0, 0, 0}};
      int u4 [K][N] = '{'{1, 0, 0, 0}, '{0, 0, 0, 0}};
      int v1 [N] = '{0, 9, 8, 16};
      int vw [N] = '{8, 0, 0, 0};
      int vb [N] = '{4, 5, 12, -4};
      int z1 [N] = '{0, 0, 0, 0};

      rst   = 1'b1;
      start = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_msg", msg, 0);
      chk("reset_noisy", noisy, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op(mk_vec(s1), mk_vec(z2), mk_poly(v1), 0, 0);
      run_op(mk_vec(sw), mk_vec(uw), mk_poly(vw), 0, 0);
      run_op(mk_vec(s1), mk_vec(z2), mk_poly(vb), 0, 0);
      run_op(mk_vec(s1), mk_vec(u4), mk_poly(z1), 0, 0);
      run_op(mk_vec(s1), mk_vec(z2), mk_poly(v1), 10, 0);
      run_op(mk_vec(s1), mk_vec(z2), mk_poly(v1), 0, 12);
      run_op(mk_vec(s1), mk_vec(z2), mk_poly(v1), 0, 0);

      for (int t = 0; t < 20; t++) begin
         polyvec_t rs, ru;
         poly_t    rv;
         scramble();
         rs = secretkey;
         ru = u;
         rv = v;
         run_op(rs, ru, rv, 0, 0);
      end

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
